// File: rtl/rd_ptr_empty.sv
// Read-side pointer / empty-flag generator for the dual-clock async FIFO.
// Optional read-domain fill level and threshold almost-empty: define RD_LEVEL_EN.
module rd_ptr_empty #(
  parameter int C_DEPTH_BITS    = 10,
  parameter int C_AEMPTY_THRESH = 4
) (
  input  logic                    RD_CLK,
  input  logic                    RD_RST,
  input  logic                    RD_EN,
  output logic                    RD_EMPTY,
  output logic                    RD_ALMOST_EMPTY,
  output logic                    RD_UNDERFLOW,
  output logic [C_DEPTH_BITS:0]   RD_COUNT,
  output logic [C_DEPTH_BITS-1:0] RD_PTR,
  output logic [C_DEPTH_BITS-1:0] RD_PTR_P1,
  input  logic [C_DEPTH_BITS-1:0] WR_PTR_GRAY,
  input  logic                    CMP_EMPTY
);

  localparam int AW = C_DEPTH_BITS;
  localparam int CW = C_DEPTH_BITS + 1;

  logic [AW-1:0] bin, bin_p1;
  logic [AW-1:0] bin_next, bin_p1_next;
  logic          e1, e2;
  logic          empty_next;
  logic          rd_ok;

  // A read is honoured only against the registered empty flag of this cycle.
  assign rd_ok       = RD_EN & ~e1;
  assign bin_next    = bin + AW'(rd_ok);
  assign bin_p1_next = bin_p1 + AW'(rd_ok);
  assign empty_next  = CMP_EMPTY | e2;
  assign RD_EMPTY    = e1;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, as real flops do.
  always_ff @(posedge RD_CLK) begin
    if (RD_RST) begin
      bin          <= '0;
      bin_p1       <= AW'(1);
      RD_PTR       <= '0;
      RD_PTR_P1    <= AW'(1);
      e1           <= 1'b1;
      e2           <= 1'b1;
      RD_UNDERFLOW <= 1'b0;
    end else begin
      bin          <= bin_next;
      bin_p1       <= bin_p1_next;
      RD_PTR       <= bin_next ^ (bin_next >> 1);
      RD_PTR_P1    <= bin_p1_next ^ (bin_p1_next >> 1);
      // Assert empty at once, release only after two clean samples.
      e1           <= empty_next;
      e2           <= CMP_EMPTY;
      if (RD_EN && e1) RD_UNDERFLOW <= 1'b1;
    end
  end

`ifdef RD_LEVEL_EN
  logic [AW-1:0] wsync1, wsync2;
  logic [AW-1:0] wbin_s;
  logic [AW-1:0] diff;
  logic [CW-1:0] count_next;

  // NOTE: every combinational output gets a value on every path, so no
  // latch can be inferred.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < AW; i++) wbin_s[i] = ^(wsync2 >> i);
  end

  // Equal pointers with the comparator showing not-empty means a full FIFO.
  assign diff       = wbin_s - bin_next;
  assign count_next = (diff == '0 && !empty_next) ? {1'b1, {AW{1'b0}}}
                                                  : {1'b0, diff};

  always_ff @(posedge RD_CLK) begin
    if (RD_RST) begin
      wsync1          <= '0;
      wsync2          <= '0;
      RD_COUNT        <= '0;
      RD_ALMOST_EMPTY <= 1'b1;
    end else begin
      wsync1          <= WR_PTR_GRAY;
      wsync2          <= wsync1;
      RD_COUNT        <= count_next;
      RD_ALMOST_EMPTY <= (count_next <= CW'(C_AEMPTY_THRESH)) | empty_next;
    end
  end
`else
  logic unused_wr_ptr;

  assign unused_wr_ptr   = ^WR_PTR_GRAY;
  assign RD_COUNT        = '0;
  assign RD_ALMOST_EMPTY = e1;
`endif

endmodule
